daq_sram_writer: RTL



---
 rtl/daq_pkg.sv | 27 ++
 rtl/daq_sram_writer_if.sv | 26 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/daq_sram_writer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ SRAM writer: FSM encoding and width helpers.
package daq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StWrite,
    StDone,
    StRelease
  } daq_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = unsigned'(i) + 32'd1;
    end
    return r;
  endfunction

  // Width of a per-channel region offset: address bits left after the channel index.
  function automatic int unsigned region_w(input int unsigned aw, input int unsigned nch);
    return aw - clog2(nch);
  endfunction

endpackage

// File: rtl/daq_sram_writer_if.sv
// SRAM write port shared between the DAQ writer (master) and the memory (slave).
interface daq_sram_writer_if #(
  parameter int unsigned dw = 32,
  parameter int unsigned aw = 10
) ();

  logic [aw-1:0] sram_addr;
  logic [dw-1:0] sram_wdata;
  logic          sram_we;
  logic          sram_ack;

  modport master (
    output sram_addr,
    output sram_wdata,
    output sram_we,
    input  sram_ack
  );

  modport slave (
    input  sram_addr,
    input  sram_wdata,
    input  sram_we,
    output sram_ack
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first requester at or after ptr_i.
module rr_arbiter
  import daq_pkg::*;
#(
  parameter int unsigned NCH = 4,
  localparam int unsigned IW = clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [IW-1:0]  idx_o,
  output logic           valid_o
);

  assign valid_o = |req_i;

  // Scan requesters starting at the pointer; the IW-bit add wraps since NCH is a power of 2.
  always_comb begin : p_select
    logic          found;
    logic [IW-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = ptr_i + IW'(k);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/daq_sram_writer.sv
// Round-robin mover from NCH channel FIFOs into per-channel circular SRAM regions.
// Optional sticky wrap interrupt with per-bit clear: define DAQ_SRAM_WRAP_IRQ_EN.
module daq_sram_writer
  import daq_pkg::*;
#(
  parameter int unsigned dw    = 32,
  parameter int unsigned aw    = 10,
  parameter int unsigned NCH   = 4,
  parameter int unsigned BURST = 8
) (
  input  logic                           wb_clk,
  input  logic                           wb_rst,
  input  logic                           master_enable,
  input  logic [NCH-1:0]                 start_sram,
  input  logic [NCH-1:0]                 fifo_empty,
  input  logic [NCH*dw-1:0]              chan_data,
  output logic [NCH-1:0]                 grant,
  output logic [NCH-1:0]                 data_done,
  daq_sram_writer_if.master              sram,
  output logic [NCH*region_w(aw,NCH)-1:0] wr_ptr_flat,
`ifdef DAQ_SRAM_WRAP_IRQ_EN
  input  logic [NCH-1:0]                 irq_clear,
`endif
  output logic [NCH-1:0]                 wrap_irq
);

  localparam int unsigned IW = clog2(NCH);
  localparam int unsigned OW = region_w(aw, NCH);

  daq_state_e     state_q;
  logic [IW-1:0]  ch_q;
  logic [IW-1:0]  rr_q;
  logic [NCH-1:0] grant_q;
  logic [NCH-1:0] done_q;
  logic [aw-1:0]  addr_q;
  logic [dw-1:0]  wdata_q;
  logic           we_q;
  logic [5:0]     cnt_q;
  logic [OW-1:0]  wr_ptr_q [NCH];

  logic [NCH-1:0] arb_gnt;
  logic [IW-1:0]  arb_idx;
  logic           arb_valid;
  logic           stop_burst;

  rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .req_i   (start_sram),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // The granted channel ran dry, withdrew its request, or the writer was disabled.
  assign stop_burst = fifo_empty[ch_q] | ~start_sram[ch_q] | ~master_enable;

  // Grant/write FSM with all outputs registered.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= StIdle;
      ch_q    <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      done_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < NCH; i++) wr_ptr_q[i] <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        StIdle: begin
          if (master_enable && arb_valid) begin
            ch_q    <= arb_idx;
            grant_q <= arb_gnt;
            cnt_q   <= '0;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          // Between words the popped FIFO has settled here, so an emptied channel ends now.
          if (cnt_q != '0 && stop_burst) begin
            grant_q <= '0;
            state_q <= StRelease;
          end else begin
            addr_q  <= {ch_q, wr_ptr_q[ch_q]};
            wdata_q <= chan_data[ch_q*dw +: dw];
            we_q    <= 1'b1;
            state_q <= StWrite;
          end
        end
        StWrite: begin
          if (sram.sram_ack) begin
            we_q             <= 1'b0;
            done_q[ch_q]     <= 1'b1;
            wr_ptr_q[ch_q]   <= wr_ptr_q[ch_q] + OW'(1);
            cnt_q            <= cnt_q + 6'd1;
            state_q          <= StDone;
          end
        end
        StDone: begin
          if (cnt_q == 6'(BURST) || stop_burst) begin
            grant_q <= '0;
            state_q <= StRelease;
          end else begin
            state_q <= StGrant;
          end
        end
        StRelease: begin
          rr_q    <= ch_q + IW'(1);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant           = grant_q;
  assign data_done       = done_q;
  assign sram.sram_addr  = addr_q;
  assign sram.sram_wdata = wdata_q;
  assign sram.sram_we    = we_q;

  for (genvar g = 0; g < NCH; g++) begin : g_flat
    assign wr_ptr_flat[g*OW +: OW] = wr_ptr_q[g];
  end

`ifdef DAQ_SRAM_WRAP_IRQ_EN
  logic [NCH-1:0] wrap_set;
  logic [NCH-1:0] wrap_q;

  // A wrap is the accepted write that moves a pointer from all-ones back to zero.
  always_comb begin
    wrap_set = '0;
    if (state_q == StWrite && sram.sram_ack && (&wr_ptr_q[ch_q])) wrap_set[ch_q] = 1'b1;
  end

  // Sticky flags; a set in the same cycle as a clear wins.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) wrap_q <= '0;
    else        wrap_q <= (wrap_q & ~irq_clear) | wrap_set;
  end

  assign wrap_irq = wrap_q;
`else
  assign wrap_irq = '0;
`endif

endmodule
